// File: rtl/ixu_pkg.sv
// Shared types for the integer-execution divider scheduler: request payload,
// scheduler FSM states and default widths.
package ixu_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_TAG_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } div_sched_state_t;

  typedef struct packed {
    logic                 is_unsigned;
    logic                 opcode;
    logic [DIV_XLEN-1:0]  a;
    logic [DIV_XLEN-1:0]  b;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

endpackage

// File: rtl/ixu_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester and
// moves to the other side whenever a grant is issued.
module ixu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || !ptr_q)) begin
        gnt_o[0] = 1'b1;
        ptr_d    = 1'b1;
      end else if (req_i[1]) begin
        gnt_o[1] = 1'b1;
        ptr_d    = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ixu_div_sched.sv
// Shares one iterative divider between two issue ports: round-robin into a
// single pending slot, start/done sequencing, and a held writeback register.
module ixu_div_sched
  import ixu_pkg::*;
#(
  parameter int unsigned TAG_W = DIV_TAG_W,
  parameter int unsigned XLEN  = DIV_XLEN
) (
  input  logic             core_clock_i,
  input  logic             core_reset_ni,
  input  logic             core_flush_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic             req0_unsigned_i,
  input  logic             req0_opcode_i,
  input  logic [XLEN-1:0]  req0_a_i,
  input  logic [XLEN-1:0]  req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic             req1_unsigned_i,
  input  logic             req1_opcode_i,
  input  logic [XLEN-1:0]  req1_a_i,
  input  logic [XLEN-1:0]  req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  output logic             div_start_o,
  output logic             div_unsigned_o,
  output logic             div_opcode_o,
  output logic [XLEN-1:0]  div_a_o,
  output logic [XLEN-1:0]  div_b_o,
  output logic             div_flush_o,
  input  logic             div_busy_i,
  input  logic             div_done_i,
  input  logic             div_dbz_i,
  input  logic             div_overflow_i,
  input  logic [XLEN-1:0]  div_res_i,

  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [XLEN-1:0]  wb_res_o,
  output logic             wb_dbz_o,
  output logic             wb_ovf_o
);

  div_sched_state_t state_q, state_d;
  logic             rst_hold_q;
  logic             pend_v_q, pend_v_d;
  div_req_t         pend_q, pend_d;
  logic [TAG_W-1:0] exec_tag_q, exec_tag_d;
  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [XLEN-1:0]  wb_res_q, wb_res_d;
  logic             wb_dbz_q, wb_dbz_d;
  logic             wb_ovf_q, wb_ovf_d;

  logic             accept;
  logic [1:0]       gnt;

  assign div_flush_o = core_flush_i | rst_hold_q;
  assign div_start_o = (state_q == IDLE) & pend_v_q & ~div_busy_i & ~div_done_i
                     & ~core_flush_i;
  // The slot refills in the same cycle it hands its operation to the divider.
  assign accept      = ~rst_hold_q & ~core_flush_i & (~pend_v_q | div_start_o);

  ixu_rr_arb2 u_arb (
    .clk   (core_clock_i),
    .rst_n (core_reset_ni),
    .en_i  (accept),
    .req_i ({req1_valid_i, req0_valid_i}),
    .gnt_o (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  assign div_unsigned_o = pend_q.is_unsigned;
  assign div_opcode_o   = pend_q.opcode;
  assign div_a_o        = pend_q.a;
  assign div_b_o        = pend_q.b;

  assign wb_valid_o = wb_valid_q;
  assign wb_tag_o   = wb_tag_q;
  assign wb_res_o   = wb_res_q;
  assign wb_dbz_o   = wb_dbz_q;
  assign wb_ovf_o   = wb_ovf_q;

  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (gnt[0]) begin
      pend_d = '{is_unsigned: req0_unsigned_i, opcode: req0_opcode_i,
                 a: req0_a_i, b: req0_b_i, tag: DIV_TAG_W'(req0_tag_i)};
    end else if (gnt[1]) begin
      pend_d = '{is_unsigned: req1_unsigned_i, opcode: req1_opcode_i,
                 a: req1_a_i, b: req1_b_i, tag: DIV_TAG_W'(req1_tag_i)};
    end
    if (core_flush_i)    pend_v_d = 1'b0;
    else if (|gnt)       pend_v_d = 1'b1;
    else if (div_start_o) pend_v_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    exec_tag_d = exec_tag_q;
    wb_valid_d = wb_valid_q;
    wb_tag_d   = wb_tag_q;
    wb_res_d   = wb_res_q;
    wb_dbz_d   = wb_dbz_q;
    wb_ovf_d   = wb_ovf_q;
    if (core_flush_i) begin
      // A done arriving together with the flush is dropped here.
      state_d    = IDLE;
      wb_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (div_start_o) begin
          exec_tag_d = TAG_W'(pend_q.tag);
          state_d    = RUN;
        end
        RUN: if (div_done_i) begin
          wb_tag_d   = exec_tag_q;
          wb_res_d   = div_res_i;
          wb_dbz_d   = div_dbz_i;
          wb_ovf_d   = div_overflow_i;
          wb_valid_d = 1'b1;
          state_d    = WB;
        end
        WB: if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      rst_hold_q <= 1'b1;
      pend_v_q   <= 1'b0;
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
    end else begin
      rst_hold_q <= 1'b0;
      pend_v_q   <= pend_v_d;
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // NOTE: payload registers are qualified by their valid bits, so they carry
  // no reset; only the control state above is reset.
  always_ff @(posedge core_clock_i) begin
    pend_q     <= pend_d;
    exec_tag_q <= exec_tag_d;
    wb_tag_q   <= wb_tag_d;
    wb_res_q   <= wb_res_d;
    wb_dbz_q   <= wb_dbz_d;
    wb_ovf_q   <= wb_ovf_d;
  end

endmodule
